// File: rtl/w0rm_bus_pkg.sv
// Shared sizing helpers for the response merger: clog2, port-id width, flattened-bus slicing.
package w0rm_bus_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // A 1-bit field is still needed when only one index bit would be zero-width.
    function automatic int port_id_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/w0rm_bus_response_merger_if.sv
// Bundle of peripheral response inputs and merged CPU-side outputs.
// bus_port_o exists only when W0RM_BUS_MERGE_PORT_ID_EN is defined.
interface w0rm_bus_response_merger_if
    import w0rm_bus_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]            bus_valid_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] bus_data_i;
    logic                            overflow_clear_i;
    logic                            bus_valid_o;
    logic [DATA_WIDTH-1:0]           bus_data_o;
    logic [NUM_PORTS-1:0]            bus_overflow_o;
    logic                            bus_busy_o;
`ifdef W0RM_BUS_MERGE_PORT_ID_EN
    logic [port_id_w(NUM_PORTS)-1:0] bus_port_o;

    modport master (output bus_valid_i, bus_data_i, overflow_clear_i,
                    input  bus_valid_o, bus_data_o, bus_overflow_o, bus_busy_o, bus_port_o);
    modport slave  (input  bus_valid_i, bus_data_i, overflow_clear_i,
                    output bus_valid_o, bus_data_o, bus_overflow_o, bus_busy_o, bus_port_o);
`else
    modport master (output bus_valid_i, bus_data_i, overflow_clear_i,
                    input  bus_valid_o, bus_data_o, bus_overflow_o, bus_busy_o);
    modport slave  (input  bus_valid_i, bus_data_i, overflow_clear_i,
                    output bus_valid_o, bus_data_o, bus_overflow_o, bus_busy_o);
`endif
endinterface

// File: rtl/w0rm_bus_merge_fifo.sv
// Per-port response queue; a push into a full queue lands only if the head pops the same cycle.
module w0rm_bus_merge_fifo
    import w0rm_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count
);
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign count = count_q;

endmodule

// File: rtl/w0rm_bus_response_merger.sv
// N-port round-robin merger of peripheral read responses onto one return bus.
// Optional granted-port output: define W0RM_BUS_MERGE_PORT_ID_EN.
module w0rm_bus_response_merger
    import w0rm_bus_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                       bus_clock,
    input logic                       cpu_reset,
    w0rm_bus_response_merger_if.slave bus
);
    localparam int PW = port_id_w(NUM_PORTS);
    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0]                 empty, full, pop, push, cand, ovf_new, nonempty_nxt;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head, in_data;
    logic [NUM_PORTS-1:0][CW-1:0]         count;

    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  valid_q, valid_d, busy_q, busy_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0]  ovf_q, ovf_d;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic sel, acc;
        assign in_data[k] = bus.bus_data_i[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        assign cand[k]    = !empty[k] || bus.bus_valid_i[k];
        assign sel        = gnt_any && (gnt_idx == PW'(k));
        assign pop[k]     = sel && !empty[k];
        // An empty granted port forwards its input directly, so it must not also queue it.
        assign push[k]    = bus.bus_valid_i[k] && !(sel && empty[k]);
        assign acc        = push[k] && (!full[k] || pop[k]);
        assign ovf_new[k] = push[k] && full[k] && !pop[k];
        assign nonempty_nxt[k] = acc || (count[k] > CW'(pop[k]));

        w0rm_bus_merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (bus_clock),
            .rst   (cpu_reset),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data[k]),
            .dout  (head[k]),
            .empty (empty[k]),
            .full  (full[k]),
            .count (count[k])
        );
    end

    // Search starts one past the last winner so every port gets a turn.
    always_comb begin
        int sum;
        sum      = 0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NUM_PORTS) sum -= NUM_PORTS;
            if (!gnt_any && cand[PW'(sum)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(sum);
            end
        end
        gnt_data = empty[gnt_idx] ? in_data[gnt_idx] : head[gnt_idx];
    end

    always_comb begin
        valid_d = gnt_any;
        busy_d  = |nonempty_nxt;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ovf_d   = (bus.overflow_clear_i ? '0 : ovf_q) | ovf_new;
        if (gnt_any) begin
            ptr_d  = gnt_idx;
            data_d = gnt_data;
        end
    end

    always_ff @(posedge bus_clock) begin
        if (cpu_reset) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= PW'(NUM_PORTS - 1);
            data_q  <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.bus_valid_o    = valid_q;
    assign bus.bus_data_o     = data_q;
    assign bus.bus_overflow_o = ovf_q;
    assign bus.bus_busy_o     = busy_q;

`ifdef W0RM_BUS_MERGE_PORT_ID_EN
    logic [PW-1:0] port_q, port_d;

    always_comb begin
        port_d = port_q;
        if (gnt_any) port_d = gnt_idx;
    end

    always_ff @(posedge bus_clock) begin
        if (cpu_reset) port_q <= '0;
        else           port_q <= port_d;
    end

    assign bus.bus_port_o = port_q;
`endif

endmodule

// File: tb/tb_w0rm_bus_response_merger.sv
// Directed bench for the 4-port, 32-bit, depth-4 response merger.
module tb_w0rm_bus_response_merger;
    import w0rm_bus_pkg::*;

    logic bus_clock = 1'b0;
    logic cpu_reset;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] t3_drain [7]  = '{32'h205, 32'h106, 32'h206, 32'h107, 32'h207, 32'h108, 32'h209};
    logic [3:0]  t4_v     [12] = '{4'b1001, 4'b1010, 4'b1100, 4'b1000, 4'b1001, 4'b0010,
                                   4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] t4_exp   [12] = '{32'h40, 32'h41, 32'h42, 32'h50, 32'h44, 32'h45,
                                   32'h46, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55};

    w0rm_bus_response_merger_if #(.NUM_PORTS(4), .DATA_WIDTH(32)) bif ();

    w0rm_bus_response_merger #(.NUM_PORTS(4), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .bus_clock (bus_clock),
        .cpu_reset (cpu_reset),
        .bus       (bif)
    );

    always #5 bus_clock = ~bus_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic clr);
        bif.bus_valid_i      = v;
        bif.bus_data_i       = {d3, d2, d1, d0};
        bif.overflow_clear_i = clr;
    endtask

    task automatic tick();
        @(posedge bus_clock);
        #1;
    endtask

    task automatic out(input string tag, input logic v, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(bif.bus_valid_o), 64'(v));
        if (v) chk({tag, "_data"}, 64'(bif.bus_data_o), 64'(d));
    endtask

    initial begin
        logic [31:0] e;
        int          n3;
        cpu_reset = 1'b1;
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk("rst_valid", 64'(bif.bus_valid_o), 64'd0);
        chk("rst_data",  64'(bif.bus_data_o), 64'd0);
        chk("rst_ovf",   64'(bif.bus_overflow_o), 64'd0);
        chk("rst_busy",  64'(bif.bus_busy_o), 64'd0);
`ifdef W0RM_BUS_MERGE_PORT_ID_EN
        chk("rst_port",  64'(bif.bus_port_o), 64'd0);
`endif
        cpu_reset = 1'b0;

        // single uncontended word on port 2
        repeat (8) tick();
        drive(4'b0100, 0, 0, 32'hDEADBEEF, 0, 1'b0);
        tick();
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        out("t1", 1'b1, 32'hDEADBEEF);
        chk("t1_busy", 64'(bif.bus_busy_o), 64'd0);
`ifdef W0RM_BUS_MERGE_PORT_ID_EN
        chk("t1_port", 64'(bif.bus_port_o), 64'd2);
`endif
        tick();
        chk("t1_idle_valid", 64'(bif.bus_valid_o), 64'd0);
        chk("t1_hold_data",  64'(bif.bus_data_o), 64'hDEADBEEF);

        // four simultaneous words drain in port order
        cpu_reset = 1'b1; tick(); cpu_reset = 1'b0;
        drive(4'b1111, 32'h10, 32'h11, 32'h12, 32'h13, 1'b0);
        tick();
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            out($sformatf("t2_%0d", i), 1'b1, 32'h10 + 32'(i));
            chk($sformatf("t2_busy_%0d", i), 64'(bif.bus_busy_o), 64'(i < 3));
            tick();
        end
        out("t2_end", 1'b0, 32'h0);

        // ports 0 and 1 hammered: alternation, then overflow on 1 then 0
        for (int c = 0; c < 10; c++) begin
            drive(4'b0011, 32'h100 + 32'(c), 32'h200 + 32'(c), 0, 0, 1'b0);
            tick();
            e = (c % 2 == 0) ? 32'h100 + 32'(c / 2) : 32'h200 + 32'(c / 2);
            out($sformatf("t3_%0d", c), 1'b1, e);
            chk($sformatf("t3_ovf_%0d", c), 64'(bif.bus_overflow_o),
                (c == 8) ? 64'h2 : (c == 9) ? 64'h3 : 64'h0);
        end

        // clear coincides with a fresh drop on port 1
        drive(4'b0010, 0, 32'h20A, 0, 0, 1'b1);
        tick();
        out("t5_race", 1'b1, 32'h105);
        chk("t5_race_ovf", 64'(bif.bus_overflow_o), 64'h2);
        drive(4'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            drive(4'b0, 0, 0, 0, 0, 1'b0);
            out($sformatf("t5_drain_%0d", i), 1'b1, t3_drain[i]);
            if (i == 0) chk("t5_clear_ovf", 64'(bif.bus_overflow_o), 64'h0);
        end
        tick();
        out("t5_end", 1'b0, 32'h0);
        chk("t5_end_busy", 64'(bif.bus_busy_o), 64'd0);

        // queue three words on port 0, then reset mid-stream
        drive(4'b0101, 32'h60, 0, 32'h72, 0, 1'b0); tick(); out("t6_a", 1'b1, 32'h72);
        drive(4'b1001, 32'h61, 0, 0, 32'h73, 1'b0); tick(); out("t6_b", 1'b1, 32'h73);
        drive(4'b0001, 32'h62, 0, 0, 0, 1'b0);      tick(); out("t6_c", 1'b1, 32'h60);
        drive(4'b0011, 32'h63, 32'h71, 0, 0, 1'b0); tick(); out("t6_d", 1'b1, 32'h71);
        chk("t6_busy_pre", 64'(bif.bus_busy_o), 64'd1);
        cpu_reset = 1'b1;
        drive(4'b0001, 32'h64, 0, 0, 0, 1'b0);
        tick();
        cpu_reset = 1'b0;
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        chk("t6_rst_valid", 64'(bif.bus_valid_o), 64'd0);
        chk("t6_rst_busy",  64'(bif.bus_busy_o), 64'd0);
        chk("t6_rst_data",  64'(bif.bus_data_o), 64'd0);
        tick();
        out("t6_quiet", 1'b0, 32'h0);
        chk("t6_quiet_busy", 64'(bif.bus_busy_o), 64'd0);
        drive(4'b1001, 32'h30, 0, 0, 32'h33, 1'b0);
        tick();
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        out("t6_p0", 1'b1, 32'h30);
`ifdef W0RM_BUS_MERGE_PORT_ID_EN
        chk("t6_p0_port", 64'(bif.bus_port_o), 64'd0);
`endif
        tick();
        out("t6_p3", 1'b1, 32'h33);
        chk("t6_p3_busy", 64'(bif.bus_busy_o), 64'd0);
`ifdef W0RM_BUS_MERGE_PORT_ID_EN
        chk("t6_p3_port", 64'(bif.bus_port_o), 64'd3);
`endif

        // fill port 3 while others win, then push into it while full and popping
        n3 = 0;
        for (int c = 0; c < 12; c++) begin
            drive(t4_v[c], 32'h40 + 32'(c), 32'h40 + 32'(c), 32'h40 + 32'(c), 32'h50 + 32'(n3), 1'b0);
            if (t4_v[c][3]) n3++;
            tick();
            out($sformatf("t4_%0d", c), 1'b1, t4_exp[c]);
            chk($sformatf("t4_ovf_%0d", c), 64'(bif.bus_overflow_o), 64'h0);
        end
        drive(4'b0, 0, 0, 0, 0, 1'b0);
        tick();
        out("t4_end", 1'b0, 32'h0);
        chk("t4_end_busy", 64'(bif.bus_busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w0rm_bus_response_merger.md
Name: w0rm_bus_response_merger

Overview:
Parametrised N-port merger for peripheral read responses onto the single CPU return bus (mem_data_i/mem_valid_i, or inst_data_i/inst_valid_i).
Successor to the fixed 2-/4-port bus extenders:
- port count and width are generic;
- each port has a small FIFO, so simultaneous responses are queued instead of corrupted;
- round-robin arbitration, sticky per-port overflow flags.
Sits between the peripherals' mem_valid_o/mem_data_o pairs and the core.

Parameters:
NUM_PORTS, 4, number of response ports (2..16)
DATA_WIDTH, 32, response word width (e.g. 48 for instruction data plus address tag)
FIFO_DEPTH, 4, per-port queue depth in words (power of 2, >=2)

Ports:
bus_clock  input  1  single clock; all logic on rising edge
cpu_reset  input  1  synchronous, active-high reset
bus_valid_i  input  NUM_PORTS  per-port response valid, one-cycle pulse per word
bus_data_i  input  NUM_PORTS*DATA_WIDTH  flattened; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
overflow_clear_i  input  1  clears all overflow flags
bus_valid_o  output  1  merged response valid, one-cycle pulse per word
bus_data_o  output  DATA_WIDTH  merged response data
bus_overflow_o  output  NUM_PORTS  sticky: port k dropped a word
bus_busy_o  output  1  any port FIFO non-empty

Behaviour:
- Reset (cpu_reset high at edge):
  - all FIFOs emptied;
  - bus_valid_o=0, bus_data_o=0, bus_overflow_o=0, bus_busy_o=0;
  - round-robin pointer = NUM_PORTS-1, so port 0 has first priority.
  - Reset mid-operation discards queued words without emitting them. Inputs arriving in the reset cycle are ignored.
- No backpressure: the downstream is always ready. Exactly one word is emitted per cycle while any candidate exists.
- Candidate for port k in cycle t:
  - head of FIFO k if non-empty;
  - otherwise bus_data_i[k] if bus_valid_i[k] (bypass).
- Arbitration:
  - grant the first candidate found searching k = ptr+1, ptr+2, ... modulo NUM_PORTS;
  - ptr <= granted index;
  - ptr unchanged when there is no grant.
- Output register:
  - bus_valid_o <= grant_any;
  - bus_data_o <= granted word, updated only on grant (holds last value otherwise).
- Latency: 1 cycle uncontended (input at edge t, output valid after edge t+1). Contended words wait one extra cycle per word ahead of them.
- Push rule: a bus_valid_i[k] word not consumed via bypass is written to FIFO k.
  - Pop of the head and push in the same cycle both happen, and order is preserved.
- Per-port ordering is strict FIFO. No ordering is guaranteed across ports.
- FIFO full boundary:
  - push to a full FIFO with no pop the same cycle drops the word and sets bus_overflow_o[k] <= 1;
  - full with a same-cycle pop accepts the word;
  - occupancy counter is clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
- overflow_clear_i clears all flags.
  - A same-cycle new overflow on port k wins: the flag stays 1.
- bus_busy_o is registered: the OR of FIFO non-empty after the current edge's updates.
- No internal FSM beyond the arbiter pointer and per-FIFO pointers/counters.

Optional Feature:
Macro W0RM_BUS_MERGE_PORT_ID_EN.
- Defined: adds output bus_port_o, width clog2(NUM_PORTS), registered together with bus_data_o. It carries the granted port index and resets to 0.
- Undefined: port absent, and no index register is synthesised.

Decomposition:
- Package w0rm_bus_pkg:
  - clog2 constant function;
  - PORT_ID width helper;
  - port-slice index macro/function for the flattened bus.
- One natural sub-module, w0rm_bus_merge_fifo (parametrised DATA_WIDTH, FIFO_DEPTH).
  - Ports: push, pop, din, dout(head), empty, full, count.
  - Instantiated NUM_PORTS times in a generate loop.
- Arbiter and output register stay in the top module.

Test Plan:
1. Single port, no contention: port 2 pulses 0xDEADBEEF at cycle 10 -> bus_valid_o=1 at cycle 11 with 0xDEADBEEF; bus_busy_o stays 0; (PORT_ID_EN) bus_port_o=2.
2. All four ports pulse 0x10,0x11,0x12,0x13 in the same cycle after reset -> four consecutive output cycles in order 0x10,0x11,0x12,0x13; bus_busy_o high for 3 cycles.
3. Round-robin fairness: ports 0 and 1 both valid every cycle for 8 cycles -> outputs alternate 0,1,0,1. Then FIFO_DEPTH=4 overflow sets bus_overflow_o[0] and [1] at the expected cycle; other flags stay 0.
4. Full-with-pop: fill port 3 to 4 entries while the arbiter is blocked by other ports, then push while its head is popped -> no overflow flag; all words emerge in order.
5. Overflow clear race: overflow_clear_i asserted in the same cycle as a new drop on port 1 -> bus_overflow_o[1] remains 1 and the others clear to 0.
6. Reset mid-operation: 3 words queued on port 0, cpu_reset for 1 cycle -> no further bus_valid_o; bus_busy_o=0; next input on port 3 emerges after 1 cycle, with port 0 priority restored.
